// File: rtl/psoc_audio_pkg.sv
// Shared types and constants for the audio frame scheduler.
// Frames carry left in the low half, right in the high half.
package psoc_audio_pkg;

  localparam int FRAME_W = 48;
  localparam int CH_W    = 24;
  localparam int UCNT_W  = 16;

  typedef struct packed {
    logic [CH_W-1:0] right;
    logic [CH_W-1:0] left;
  } frame_t;

  localparam frame_t FRAME_ZERO = '0;

  function automatic frame_t to_frame(input logic [FRAME_W-1:0] raw);
    frame_t f;
    f.left  = raw[CH_W-1:0];
    f.right = raw[FRAME_W-1:CH_W];
    return f;
  endfunction

endpackage

// File: rtl/psoc_sync_fifo.sv
// Single-clock FIFO with flush; pointers wrap on a power-of-two depth.
// Push into a full FIFO or pop from an empty one is ignored.
module psoc_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next-state pointers and occupancy; flush wins over everything.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/psoc_audio_sched.sv
// Round-robin two-source frame scheduler feeding the DAC.
// Handles underrun by mute or hold, counts underruns, flags low fill.
module psoc_audio_sched
  import psoc_audio_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int LOW_WM = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     hold_last,
  input  logic                     cnt_clr,
  input  logic [FRAME_W-1:0]       src0_data,
  input  logic                     src0_valid,
  output logic                     src0_ready,
  input  logic [FRAME_W-1:0]       src1_data,
  input  logic                     src1_valid,
  output logic                     src1_ready,
  output logic [FRAME_W-1:0]       dac_data,
  input  logic                     dac_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [UCNT_W-1:0]        underrun_cnt,
  output logic                     irq_low
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic              rr_q, rr_d;
  frame_t            dac_q, dac_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;

  logic              full, empty;
  logic              can_push, grant0, grant1;
  logic              push, pop, underrun;
  logic [FRAME_W-1:0] push_data;
  logic [FRAME_W-1:0] head;

  assign can_push = en & ~full;
  assign grant0   = src0_valid & (~src1_valid | ~rr_q);
  assign grant1   = src1_valid & (~src0_valid |  rr_q);

  assign src0_ready = can_push & grant0;
  assign src1_ready = can_push & grant1;
  assign push       = src0_ready | src1_ready;
  assign push_data  = src1_ready ? src1_data : src0_data;

  assign pop      = en & dac_ready & ~empty;
  assign underrun = en & dac_ready &  empty;

  psoc_sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (~en),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Pointer moves away from whichever source just transferred.
  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = src0_ready;
  end

  // DAC frame: flush to zero when disabled, update only on strobes.
  always_comb begin
    dac_d = dac_q;
    if (!en) begin
      dac_d = FRAME_ZERO;
    end else if (dac_ready) begin
      if (!empty)         dac_d = to_frame(head);
      else if (!hold_last) dac_d = FRAME_ZERO;
    end
  end

  // Saturating underrun counter; clear beats increment.
  always_comb begin
    ucnt_d = ucnt_q;
    if (cnt_clr) begin
      ucnt_d = '0;
    end else if (underrun && (ucnt_q != '1)) begin
      ucnt_d = ucnt_q + UCNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= 1'b0;
      dac_q  <= FRAME_ZERO;
      ucnt_q <= '0;
    end else begin
      rr_q   <= rr_d;
      dac_q  <= dac_d;
      ucnt_q <= ucnt_d;
    end
  end

  assign dac_data     = dac_q;
  assign underrun_cnt = ucnt_q;
  assign irq_low      = en & (level <= LW'(LOW_WM));

endmodule

// File: tb/tb_psoc_audio_sched.sv
// Directed bench for psoc_audio_sched at DEPTH=8, LOW_WM=2.
// Each task drives one scenario and checks inline.
module tb_psoc_audio_sched;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        hold_last;
  logic        cnt_clr;
  logic [47:0] src0_data;
  logic        src0_valid;
  logic        src0_ready;
  logic [47:0] src1_data;
  logic        src1_valid;
  logic        src1_ready;
  logic [47:0] dac_data;
  logic        dac_ready;
  logic [3:0]  level;
  logic [15:0] underrun_cnt;
  logic        irq_low;

  int total;
  int bad;

  psoc_audio_sched #(.DEPTH(8), .LOW_WM(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .hold_last    (hold_last),
    .cnt_clr      (cnt_clr),
    .src0_data    (src0_data),
    .src0_valid   (src0_valid),
    .src0_ready   (src0_ready),
    .src1_data    (src1_data),
    .src1_valid   (src1_valid),
    .src1_ready   (src1_ready),
    .dac_data     (dac_data),
    .dac_ready    (dac_ready),
    .level        (level),
    .underrun_cnt (underrun_cnt),
    .irq_low      (irq_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    en = 0; hold_last = 0; cnt_clr = 0; dac_ready = 0;
    src0_valid = 0; src1_valid = 0;
    src0_data = '0; src1_data = '0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    src0_valid = 1;
    #1;
    total++; if (dac_data !== 48'h0) begin bad++; $display("FAIL reset_dac got=%h exp=0", dac_data); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (underrun_cnt !== 16'h0) begin bad++; $display("FAIL reset_ucnt got=%h exp=0", underrun_cnt); end
    total++; if (irq_low !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_low); end
    total++; if (src0_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy0 got=%b exp=0", src0_ready); end
    src0_valid = 0;
  endtask

  task automatic test_single;
    en = 1;
    src0_data = {24'h000002, 24'h000001};
    src0_valid = 1;
    #1;
    total++; if ({src0_ready, src1_ready} !== 2'b10) begin bad++; $display("FAIL single_rdy got=%b exp=10", {src0_ready, src1_ready}); end
    tick();
    src0_valid = 0;
    total++; if (level !== 4'd1) begin bad++; $display("FAIL single_lvl1 got=%0d exp=1", level); end
    total++; if (irq_low !== 1'b1) begin bad++; $display("FAIL single_irq got=%b exp=1", irq_low); end
    dac_ready = 1;
    tick();
    dac_ready = 0;
    total++; if (dac_data !== 48'h000002_000001) begin bad++; $display("FAIL single_dac got=%h exp=000002000001", dac_data); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL single_lvl0 got=%0d exp=0", level); end
    total++; if (underrun_cnt !== 16'h0) begin bad++; $display("FAIL single_ucnt got=%h exp=0", underrun_cnt); end
  endtask

  function automatic logic [47:0] tag(input int k);
    logic [23:0] idx;
    idx = 24'(k / 2);
    return (k % 2 == 0) ? {24'hA0A0A0, idx} : {24'hB1B1B1, idx};
  endfunction

  task automatic test_fairness;
    int c0;
    int c1;
    logic [1:0] exp_rdy;
    do_reset();
    en = 1;
    c0 = 0; c1 = 0;
    src0_valid = 1; src1_valid = 1;
    for (int i = 0; i < 8; i++) begin
      src0_data = {24'hA0A0A0, 24'(c0)};
      src1_data = {24'hB1B1B1, 24'(c1)};
      #1;
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      total++; if ({src0_ready, src1_ready} !== exp_rdy) begin bad++; $display("FAIL fair_grant%0d got=%b exp=%b", i, {src0_ready, src1_ready}, exp_rdy); end
      tick();
      if (i % 2 == 0) c0++; else c1++;
    end
    src0_data = {24'hA0A0A0, 24'(c0)};
    src1_data = {24'hB1B1B1, 24'(c1)};
    total++; if (level !== 4'd8) begin bad++; $display("FAIL fair_level got=%0d exp=8", level); end
    total++; if ({src0_ready, src1_ready} !== 2'b00) begin bad++; $display("FAIL fair_full_rdy got=%b exp=00", {src0_ready, src1_ready}); end
    total++; if (irq_low !== 1'b0) begin bad++; $display("FAIL fair_irq got=%b exp=0", irq_low); end
    dac_ready = 1;
    #1;
    total++; if ({src0_ready, src1_ready} !== 2'b00) begin bad++; $display("FAIL full_pop_rdy got=%b exp=00", {src0_ready, src1_ready}); end
    tick();
    dac_ready = 0;
    src0_valid = 0; src1_valid = 0;
    total++; if (level !== 4'd7) begin bad++; $display("FAIL full_pop_lvl got=%0d exp=7", level); end
    total++; if (dac_data !== tag(0)) begin bad++; $display("FAIL drain0 got=%h exp=%h", dac_data, tag(0)); end
    for (int k = 1; k < 8; k++) begin
      dac_ready = 1;
      tick();
      dac_ready = 0;
      total++; if (dac_data !== tag(k)) begin bad++; $display("FAIL drain%0d got=%h exp=%h", k, dac_data, tag(k)); end
      tick();
    end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL drain_lvl got=%0d exp=0", level); end
  endtask

  task automatic test_underrun;
    hold_last = 1;
    dac_ready = 1;
    tick();
    dac_ready = 0;
    total++; if (dac_data !== tag(7)) begin bad++; $display("FAIL hold_dac got=%h exp=%h", dac_data, tag(7)); end
    total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL hold_ucnt got=%0d exp=1", underrun_cnt); end
    hold_last = 0;
    dac_ready = 1;
    tick();
    dac_ready = 0;
    total++; if (dac_data !== 48'h0) begin bad++; $display("FAIL mute_dac got=%h exp=0", dac_data); end
    total++; if (underrun_cnt !== 16'd2) begin bad++; $display("FAIL mute_ucnt got=%0d exp=2", underrun_cnt); end
  endtask

  task automatic test_back_to_back;
    src1_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      src1_data = {24'hC0C0C0, 24'(i)};
      tick();
    end
    total++; if (level !== 4'd3) begin bad++; $display("FAIL b2b_fill got=%0d exp=3", level); end
    src1_data = {24'hC0C0C0, 24'd4};
    dac_ready = 1;
    tick();
    dac_ready = 0;
    src1_valid = 0;
    total++; if (level !== 4'd3) begin bad++; $display("FAIL b2b_level got=%0d exp=3", level); end
    total++; if (dac_data !== {24'hC0C0C0, 24'd1}) begin bad++; $display("FAIL b2b_pop1 got=%h exp=%h", dac_data, {24'hC0C0C0, 24'd1}); end
    for (int i = 2; i <= 4; i++) begin
      dac_ready = 1;
      tick();
      dac_ready = 0;
      total++; if (dac_data !== {24'hC0C0C0, 24'(i)}) begin bad++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, dac_data, {24'hC0C0C0, 24'(i)}); end
    end
  endtask

  task automatic test_watermark;
    src0_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      src0_data = {24'hD0D0D0, 24'(i)};
      tick();
    end
    src0_valid = 0;
    total++; if (level !== 4'd3) begin bad++; $display("FAIL wm_level3 got=%0d exp=3", level); end
    total++; if (irq_low !== 1'b0) begin bad++; $display("FAIL wm_irq3 got=%b exp=0", irq_low); end
    dac_ready = 1;
    tick();
    dac_ready = 0;
    total++; if (irq_low !== 1'b1) begin bad++; $display("FAIL wm_irq2 got=%b exp=1", irq_low); end
    en = 0;
    tick();
    total++; if (irq_low !== 1'b0) begin bad++; $display("FAIL wm_dis_irq got=%b exp=0", irq_low); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL wm_dis_lvl got=%0d exp=0", level); end
    total++; if (dac_data !== 48'h0) begin bad++; $display("FAIL wm_dis_dac got=%h exp=0", dac_data); end
    total++; if (underrun_cnt !== 16'd2) begin bad++; $display("FAIL wm_dis_ucnt got=%0d exp=2", underrun_cnt); end
  endtask

  task automatic test_async_reset;
    en = 1;
    src0_valid = 1;
    src0_data = {24'hE0E0E0, 24'd9};
    tick();
    tick();
    src0_valid = 0;
    dac_ready = 1;
    tick();
    dac_ready = 0;
    total++; if (level !== 4'd1) begin bad++; $display("FAIL ar_pre_lvl got=%0d exp=1", level); end
    #2;
    rst_n = 0;
    en = 0;
    #1;
    total++; if (dac_data !== 48'h0) begin bad++; $display("FAIL ar_dac got=%h exp=0", dac_data); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL ar_lvl got=%0d exp=0", level); end
    total++; if (underrun_cnt !== 16'h0) begin bad++; $display("FAIL ar_ucnt got=%h exp=0", underrun_cnt); end
    total++; if (irq_low !== 1'b0) begin bad++; $display("FAIL ar_irq got=%b exp=0", irq_low); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_saturation;
    en = 1;
    hold_last = 0;
    dac_ready = 1;
    repeat (65534) tick();
    total++; if (underrun_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h exp=fffe", underrun_cnt); end
    repeat (6) tick();
    total++; if (underrun_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h exp=ffff", underrun_cnt); end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    total++; if (underrun_cnt !== 16'h0) begin bad++; $display("FAIL sat_clr got=%h exp=0", underrun_cnt); end
    tick();
    dac_ready = 0;
    total++; if (underrun_cnt !== 16'h1) begin bad++; $display("FAIL sat_after got=%h exp=1", underrun_cnt); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_fairness();
    test_underrun();
    test_back_to_back();
    test_watermark();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psoc_audio_sched.md
# psoc_audio_sched

Stereo sample-frame scheduler between the audio sample producers and `psoc_dac`. It arbitrates round-robin between two 48-bit frame sources (src0 = CPU/MMIO writes, src1 = DMA stream) into a small synchronous FIFO. On each one-cycle `dac_ready` strobe it presents the next frame to the DAC. It handles underrun by muting or holding the last frame, and reports fill level, underruns and a low-watermark interrupt.

## Interface
- `DEPTH`, 8: FIFO depth in frames; power of two, 2..64.
- `LOW_WM`, 2: `irq_low` asserts while `level <= LOW_WM`; must satisfy `0 <= LOW_WM < DEPTH`.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scheduler enable; low = flush and mute.
- `hold_last`  in  1  underrun policy: 1 = repeat last frame, 0 = output zero.
- `cnt_clr`  in  1  one-cycle pulse; clears `underrun_cnt`.
- `src0_data`  in  48  frame, left = [23:0], right = [47:24].
- `src0_valid`  in  1  src0 frame valid.
- `src0_ready`  out  1  src0 frame accepted this cycle.
- `src1_data` / `src1_valid` / `src1_ready`: same as src0.
- `dac_data`  out  48  current frame to DAC.
- `dac_ready`  in  1  DAC read strobe, one cycle wide, about every 2048 clk.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `underrun_cnt`  out  16  saturating underrun count.
- `irq_low`  out  1  low-watermark interrupt, level-type.

## Operation
- **Acceptance:** a source is accepted when `en=1`, `level<DEPTH`, its valid is high, and it holds the grant.
  - `srcN_ready` is combinational from the valids, `level` and the round-robin pointer.
  - `srcN_ready` never asserts unless `srcN_valid` is high.
- **Arbitration:** round-robin pointer `rr`, reset value 0, meaning src0 is preferred.
  - Both valid: grant goes to `src[rr]`; `rr` flips to the other source after the transfer.
  - One valid: that source is granted; `rr` is set to the other source.
  - None valid: `rr` holds.
- **Push:** at most one push per cycle, written to the FIFO tail.
- **Full FIFO:** ready is computed from the registered `level` only. A same-cycle pop does not free a slot for a same-cycle push.
- **Pop:** on `dac_ready=1` with `en=1`:
  - `level>0`: the head frame is loaded into the `dac_data` register and popped.
  - `level==0` (underrun): `dac_data` becomes 48'h0 if `hold_last=0`, or keeps its value if `hold_last=1`. `underrun_cnt` increments and saturates at 16'hFFFF.
- **Simultaneous push and pop:** `level` is unchanged, and the pointers each advance by one.
- **Disable (`en=0`):**
  - Read and write pointers and `level` go to 0 on the next edge (flush).
  - `dac_data` goes to 0, and both src readys are 0.
  - `dac_ready` is ignored, and no underruns are counted.
  - `underrun_cnt` is retained.
- **Counter clear:** `cnt_clr` takes priority over an increment in the same cycle; the counter becomes 0.
- **Interrupt:** `irq_low = en & (level <= LOW_WM)`.
- **Reset values:** `dac_data=0`, `level=0`, `underrun_cnt=0`, `rr=0`, `irq_low=0` (`en` is 0 out of reset in the SoC). FIFO contents are undefined.
- **Reset mid-operation:** asynchronous assertion of `rst_n` clears all state immediately. Frames in flight are lost.

## Timing
- **Source handshake:** a transfer happens on the edge where valid & ready. The source must hold its data while valid and not ready.
- **Push to output:** minimum latency from accepted push to `dac_data` is the push edge, plus one `dac_ready` edge when the FIFO was empty.
- **Output update:** `dac_data` changes only at edges where `dac_ready=1` or `en` falls. It is stable for the entire DAC sample period.
- **Registered outputs:** `level` and `underrun_cnt` update at the edge after the event.
- **Combinational outputs:** `irq_low` follows `level` combinationally.

## Structure
- **Package `psoc_audio_pkg`:**
  - Constants `FRAME_W=48` and `CH_W=24`.
  - Typedef `frame_t` (struct of `left`/`right`).
  - `UCNT_W=16`.
- **Sub-module `psoc_sync_fifo`:** parameterised `WIDTH`/`DEPTH`, with push, pop, flush, head, level and full/empty. It contains no arbitration.
- **Top level:** the arbiter, the `dac_data` register and the counters live in `psoc_audio_sched`.

## Test plan
- **Single source:** after reset, `en=1`, src0 pushes 24'h000001/24'h000002, then `dac_ready` pulses → `dac_data=48'h000002_000001`, `level` 1→0, `underrun_cnt=0`.
- **Fairness:** both sources continuously valid with distinct tags, 8 pushes at DEPTH=8 → grant order src0,src1,src0,…; `level=8`; both readys 0 when full.
- **Underrun policy:** FIFO empty, `dac_ready` pulse:
  - `hold_last=1` → `dac_data` unchanged, `underrun_cnt=1`.
  - `hold_last=0` → `dac_data=0`, `underrun_cnt=2`.
- **Simultaneous push/pop:**
  - `level=3`, push and `dac_ready` in the same cycle → `level=3`, FIFO order preserved.
  - At `level=8`, push stays blocked even with a same-cycle pop.
- **Watermark:** `LOW_WM=2`; fill to 3 → `irq_low=0`; one pop → `irq_low=1`; deassert `en` → `irq_low=0`, `level=0`, `dac_data=0`.
- **Reset and saturation:**
  - Assert `rst_n` low mid-stream (asynchronously, between edges) → all outputs at reset values immediately.
  - Force 65 540 underruns → `underrun_cnt=16'hFFFF`.
  - `cnt_clr` coincident with an underrun → 0.
